// File: rtl/commutation_scheduler.sv
// Commutation scheduler: tick-paced electrical position sequencer with gain ramp FSM.
// Define COMMUTATION_GAIN_RAMP_EN for stepped gain ramps; otherwise gain jumps on each tick.
module commutation_scheduler #(
    parameter int PWM_PERIOD       = 1024,
    parameter int RAMP_STEP        = 4,
    parameter int POSITION_MODULUS = 1170
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        direction,
    input  logic [11:0] speed,
    input  logic [9:0]  gain_target,
    output logic [10:0] cycle_position,
    output logic [9:0]  gain,
    output logic        update_strobe,
    output logic        running,
    output logic [1:0]  state
);

    if (PWM_PERIOD < 2 || PWM_PERIOD > 65535) begin : g_bad_period
        $error("PWM_PERIOD out of range");
    end
    if (RAMP_STEP < 1 || RAMP_STEP > 1023) begin : g_bad_step
        $error("RAMP_STEP out of range");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [11:0] MOD12 = 12'(POSITION_MODULUS);

    state_t      state_q, state_d;
    logic [15:0] period_cnt;
    logic        tick;
    logic [3:0]  frac_q, frac_d;
    logic [10:0] pos_d;
    logic [9:0]  gain_d;
    logic [12:0] phase_sum;
    logic [8:0]  step;
    logic [11:0] pos_fwd, pos_rev;
    logic [9:0]  gain_toward, gain_down;

    assign tick = (period_cnt == 16'(PWM_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt     <= '0;
            update_strobe  <= 1'b0;
            state_q        <= IDLE;
            gain           <= '0;
            cycle_position <= '0;
            frac_q         <= '0;
        end else begin
            update_strobe <= tick;
            period_cnt    <= tick ? 16'd0 : period_cnt + 16'd1;
            if (tick) begin
                state_q        <= state_d;
                gain           <= gain_d;
                cycle_position <= pos_d;
                frac_q         <= frac_d;
            end
        end
    end

    // 8.4 phase accumulator: integer part moves the position, fraction carries over
    assign phase_sum = {9'd0, frac_q} + {1'b0, speed};
    assign step      = phase_sum[12:4];
    assign pos_fwd   = {1'b0, cycle_position} + {3'd0, step};
    assign pos_rev   = {1'b0, cycle_position} - {3'd0, step};

    always_comb begin
        pos_d  = cycle_position;
        frac_d = 4'd0;
        if (state_q != IDLE) begin
            frac_d = phase_sum[3:0];
            if (direction) begin
                pos_d = (cycle_position < {2'b00, step}) ? 11'(pos_rev + MOD12) : pos_rev[10:0];
            end else begin
                pos_d = (pos_fwd >= MOD12) ? 11'(pos_fwd - MOD12) : pos_fwd[10:0];
            end
        end
    end

`ifdef COMMUTATION_GAIN_RAMP_EN
    logic [10:0] gain_up;
    logic [9:0]  gain_dn;

    assign gain_up = {1'b0, gain} + 11'(RAMP_STEP);
    assign gain_dn = gain - 10'(RAMP_STEP);

    always_comb begin
        gain_toward = gain_target;
        if (gain < gain_target) begin
            gain_toward = (gain_up >= {1'b0, gain_target}) ? gain_target : gain_up[9:0];
        end else if (gain > gain_target) begin
            gain_toward = ({1'b0, gain - gain_target} <= 11'(RAMP_STEP)) ? gain_target : gain_dn;
        end
    end

    assign gain_down = ({1'b0, gain} <= 11'(RAMP_STEP)) ? 10'd0 : gain_dn;
`else
    assign gain_toward = gain_target;
    assign gain_down   = 10'd0;
`endif

    // An enable-driven transition only changes state; the ramp resumes on the next tick
    always_comb begin
        state_d = state_q;
        gain_d  = gain;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!enable) begin
                    state_d = RAMP_DOWN;
                end else begin
                    gain_d = gain_toward;
                    if (gain_toward == gain_target) state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) state_d = RAMP_DOWN;
                else         gain_d  = gain_toward;
            end
            RAMP_DOWN: begin
                if (enable) begin
                    state_d = RAMP_UP;
                end else begin
                    gain_d = gain_down;
                    if (gain_down == 10'd0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state   = state_q;
    assign running = (state_q != IDLE);

endmodule
